// File: rtl/uart_tx_two_bytes_if.sv
// Handshake/serial bundle for the two-byte UART transmitter.
// The master side requests a word; the slave side (the transmitter) drives the line and status.
interface uart_tx_two_bytes_if;
    logic        start;
    logic [15:0] data_in;
    logic        tx;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output data_in,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  data_in,
        output tx,
        output busy,
        output done
    );
endinterface

// File: rtl/uart_tx_two_bytes.sv
// Sends a 16-bit word as two back-to-back UART frames, high byte first, LSB first per byte.
// Define UART_TX_PARITY_EN to insert an even-parity bit after bit 7 of each byte.
module uart_tx_two_bytes #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic                clock,
    input  logic                reset,
    uart_tx_two_bytes_if.slave  bus
);

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BITS  = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY_BIT = 3'd3,
`endif
        STOP_BIT   = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic [BAUD_W-1:0] baud_reg, baud_next;
    logic [2:0]        bit_idx_reg, bit_idx_next;
    logic              byte_idx_reg, byte_idx_next;
    logic [15:0]       word_reg, word_next;
    logic              tx_reg, tx_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;

    logic [7:0]        frame_byte [2];
    logic [7:0]        cur_byte;
    logic [2:0]        bit_idx_inc;
    logic              bit_end;

    // frame_byte[0] goes out first, so it is the high byte of the latched word
    for (genvar gi = 0; gi < 2; gi++) begin : g_bytes
        assign frame_byte[gi] = word_reg[15 - 8*gi -: 8];
    end

    assign cur_byte    = frame_byte[byte_idx_reg];
    assign bit_idx_inc = bit_idx_reg + 3'd1;
    assign bit_end     = (baud_reg == BAUD_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            baud_reg     <= '0;
            bit_idx_reg  <= '0;
            byte_idx_reg <= 1'b0;
            word_reg     <= '0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_idx_reg  <= bit_idx_next;
            byte_idx_reg <= byte_idx_next;
            word_reg     <= word_next;
            tx_reg       <= tx_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    // tx_next always carries the level of the bit the next state will be in,
    // so the line changes on the same edge as the state and stays registered.
    always_comb begin
        state_next    = state_reg;
        baud_next     = baud_reg;
        bit_idx_next  = bit_idx_reg;
        byte_idx_next = byte_idx_reg;
        word_next     = word_reg;
        tx_next       = tx_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;

        if (state_reg != IDLE) begin
            baud_next = bit_end ? '0 : baud_reg + BAUD_W'(1);
        end

        case (state_reg)
            IDLE: begin
                tx_next       = 1'b1;
                busy_next     = 1'b0;
                baud_next     = '0;
                bit_idx_next  = '0;
                byte_idx_next = 1'b0;
                if (bus.start) begin
                    word_next  = bus.data_in;
                    state_next = START_BIT;
                    tx_next    = 1'b0;
                    busy_next  = 1'b1;
                end
            end

            START_BIT: begin
                if (bit_end) begin
                    state_next   = DATA_BITS;
                    bit_idx_next = '0;
                    tx_next      = cur_byte[0];
                end
            end

            DATA_BITS: begin
                if (bit_end) begin
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY_BIT;
                        tx_next    = ^cur_byte;
`else
                        state_next = STOP_BIT;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        bit_idx_next = bit_idx_inc;
                        tx_next      = cur_byte[bit_idx_inc];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY_BIT: begin
                if (bit_end) begin
                    state_next = STOP_BIT;
                    tx_next    = 1'b1;
                end
            end
`endif

            STOP_BIT: begin
                if (bit_end) begin
                    if (!byte_idx_reg) begin
                        // second byte follows with no idle gap
                        byte_idx_next = 1'b1;
                        state_next    = START_BIT;
                        tx_next       = 1'b0;
                    end else begin
                        byte_idx_next = 1'b0;
                        state_next    = IDLE;
                        tx_next       = 1'b1;
                        busy_next     = 1'b0;
                        done_next     = 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign bus.tx   = tx_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;

endmodule

// File: tb/tb_uart_tx_two_bytes.sv
// Scoreboarded bench for uart_tx_two_bytes: stimulus queues expected bytes, a line monitor
// decodes each serial frame and compares; status timing is checked from per-cycle logs.
module tb_uart_tx_two_bytes;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int BUSY_CYC = 2 * FRAME_BITS * CPB;

    logic clock;
    logic reset;
    uart_tx_two_bytes_if bus();

    uart_tx_two_bytes #(.CLKS_PER_BIT(CPB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q [$];

    logic       tx_log   [0:255];
    logic       busy_log [0:255];
    logic       done_log [0:255];
    int         busy_cnt;
    int         done_cnt;
    int         done_idx [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0h", name, act);
        end
    endtask

    // ---------------- line monitor / scoreboard ----------------
    logic [10:0] mon_bits;
    logic        mon_abort;
    logic [7:0]  mon_exp;

    initial begin : monitor
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && bus.tx === 1'b0) begin
                mon_abort = 1'b0;
                mon_bits  = '1;
                for (int b = 0; b < FRAME_BITS; b++) begin
                    for (int c = 0; c < ((b == 0) ? CPB / 2 : CPB); c++) begin
                        @(negedge clock);
                        if (reset !== 1'b1) begin
                            mon_abort = 1'b1;
                            break;
                        end
                    end
                    if (mon_abort) break;
                    mon_bits[b] = bus.tx;
                end
                if (!mon_abort) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", {24'd0, mon_bits[8:1]}, 32'hFFFF_FFFF);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("frame_data", {24'd0, mon_bits[8:1]}, {24'd0, mon_exp});
                        check("frame_start_stop", {30'd0, mon_bits[0], mon_bits[FRAME_BITS-1]}, 32'd1);
`ifdef UART_TX_PARITY_EN
                        check("frame_parity", {31'd0, mon_bits[9]}, {31'd0, ^mon_exp});
`endif
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic accept(input logic [15:0] w, input logic hold);
        @(negedge clock);
        bus.start   = 1'b1;
        bus.data_in = w;
        @(posedge clock);
        #1;
        check("accept_busy_tx", {30'd0, bus.busy, bus.tx}, 32'd2);
        if (!hold) bus.start = 1'b0;
    endtask

    task automatic observe(input int n, input int set_at, input logic [15:0] set_data,
                           input int clr_at, input int rst_at);
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) done_idx[i] = -1;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            tx_log[k]   = bus.tx;
            busy_log[k] = bus.busy;
            done_log[k] = bus.done;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                if (done_cnt < 4) done_idx[done_cnt] = k;
                done_cnt++;
            end
            if (k == set_at) begin
                bus.start   = 1'b1;
                bus.data_in = set_data;
            end
            if (k == clr_at) bus.start = 1'b0;
            if (k == rst_at) begin
                reset = 1'b0;
                exp_q.delete();
                #1;
                check("async_reset_tx_busy", {30'd0, bus.tx, bus.busy}, 32'd2);
            end
        end
    endtask

    int bad;

    initial begin
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.data_in = 16'h0000;
        repeat (5) @(negedge clock);
        check("reset_state", {29'd0, bus.tx, bus.busy, bus.done}, 32'd4);
        reset = 1'b1;

        // idle line after reset release
        observe(100, -1, 16'h0, -1, -1);
        bad = 0;
        for (int k = 0; k < 100; k++) if (tx_log[k] !== 1'b1 || done_log[k] !== 1'b0) bad++;
        check("idle_line_high", bad, 0);
        check("idle_busy_cycles", busy_cnt, 0);

        // single word; data_in changes after acceptance must not matter
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        accept(16'hA55A, 1'b0);
        bus.data_in = 16'h0000;
        observe(BUSY_CYC + 10, -1, 16'h0, -1, -1);
        check("w1_busy_cycles", busy_cnt, BUSY_CYC);
        check("w1_done_count", done_cnt, 1);
        check("w1_done_at", done_idx[0], BUSY_CYC);
        check("w1_tx_in_done_cycle", {31'd0, tx_log[BUSY_CYC]}, 32'd1);

        // start while busy is ignored
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        accept(16'hA55A, 1'b0);
        observe(BUSY_CYC + 10, 30, 16'hFFFF, 31, -1);
        check("ign_busy_cycles", busy_cnt, BUSY_CYC);
        check("ign_done_count", done_cnt, 1);

        // start held through done: back-to-back words
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h3C);
        accept(16'h1234, 1'b1);
        observe(2 * BUSY_CYC + 10, 5, 16'hC33C, BUSY_CYC + 20, -1);
        check("b2b_done_count", done_cnt, 2);
        check("b2b_done0_at", done_idx[0], BUSY_CYC);
        check("b2b_done1_at", done_idx[1], 2 * BUSY_CYC + 1);
        check("b2b_gap_tx", {30'd0, tx_log[BUSY_CYC], tx_log[BUSY_CYC + 1]}, 32'd2);
        check("b2b_gap_busy", {30'd0, busy_log[BUSY_CYC], busy_log[BUSY_CYC + 1]}, 32'd1);

        // reset mid-transfer, then a clean word
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        accept(16'hA55A, 1'b0);
        observe(40, -1, 16'h0, -1, 30);
        check("pre_reset_line", {30'd0, tx_log[30], busy_log[30]}, 32'd1);
        bad = 0;
        for (int k = 31; k < 40; k++)
            if (tx_log[k] !== 1'b1 || busy_log[k] !== 1'b0 || done_log[k] !== 1'b0) bad++;
        check("held_in_reset", bad, 0);
        check("reset_no_done", done_cnt, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        accept(16'h0001, 1'b0);
        observe(BUSY_CYC + 10, -1, 16'h0, -1, -1);
        check("post_reset_busy_cycles", busy_cnt, BUSY_CYC);
        check("post_reset_done_at", done_idx[0], BUSY_CYC);

`ifdef UART_TX_PARITY_EN
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h01);
        accept(16'h0701, 1'b0);
        observe(BUSY_CYC + 10, -1, 16'h0, -1, -1);
        check("par_busy_cycles", busy_cnt, 88);
        check("par_done_count", done_cnt, 1);
`endif

        repeat (10) @(negedge clock);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
